sha256_msg_schedule: RTL and testbench

Generates the SHA-256 message schedule W[0..63] from one 512-bit padded message block, emitting one 32-bit word per handshake. It sits between the block/padding front end and the compression-round stage. It uses a 16-word sliding window and computes the small-sigma functions with the existing `rotate_right` primitive. One block is processed at a time, with full backpressure on the output.

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/rotate_right.sv | 18 +
 rtl/sha256_w_next.sv | 34 +++
 rtl/sha256_msg_schedule.sv | 88 ++++++++
 tb/tb_sha256_msg_schedule.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 widths, word/block types and sigma rotate amounts.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int ROUNDS  = 64;
    localparam int BLOCK_W = 16 * WORD_W;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    // Small-sigma amounts; the compression stage reuses the same naming.
    localparam int c_S0_ROT_A = 7;
    localparam int c_S0_ROT_B = 18;
    localparam int c_S0_SHR   = 3;
    localparam int c_S1_ROT_A = 17;
    localparam int c_S1_ROT_B = 19;
    localparam int c_S1_SHR   = 10;

endpackage
`default_nettype wire

// File: rtl/rotate_right.sv
`default_nettype none
// ============================================================================
// Module      : rotate_right
// Description : Constant-amount right rotate of a WIDTH-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module rotate_right #(
    parameter int WIDTH  = 32,
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = (din >> AMOUNT) | (din << (WIDTH - AMOUNT));

endmodule
`default_nettype wire

// File: rtl/sha256_w_next.sv
`default_nettype none
// ============================================================================
// Module      : sha256_w_next
// Description : Next schedule word s1(w14) + w9 + s0(w1) + w0, mod 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [31:0] win0,
    input  logic [31:0] win1,
    input  logic [31:0] win9,
    input  logic [31:0] win14,
    output logic [31:0] w_new
);

    logic [31:0] w_s0_a;
    logic [31:0] w_s0_b;
    logic [31:0] w_s1_a;
    logic [31:0] w_s1_b;
    logic [31:0] w_s0;
    logic [31:0] w_s1;

    rotate_right #(.WIDTH(32), .AMOUNT(c_S0_ROT_A)) u_s0_rot_a (.din(win1),  .dout(w_s0_a));
    rotate_right #(.WIDTH(32), .AMOUNT(c_S0_ROT_B)) u_s0_rot_b (.din(win1),  .dout(w_s0_b));
    rotate_right #(.WIDTH(32), .AMOUNT(c_S1_ROT_A)) u_s1_rot_a (.din(win14), .dout(w_s1_a));
    rotate_right #(.WIDTH(32), .AMOUNT(c_S1_ROT_B)) u_s1_rot_b (.din(win14), .dout(w_s1_b));

    assign w_s0  = w_s0_a ^ w_s0_b ^ (win1  >> c_S0_SHR);
    assign w_s1  = w_s1_a ^ w_s1_b ^ (win14 >> c_S1_SHR);
    assign w_new = w_s1 + win9 + w_s0 + win0;

endmodule
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_schedule
// Description : Streams W[0..63] for one 512-bit block through a 16-word window.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [16*WORD_W-1:0] blk_data,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [WORD_W-1:0]   w_data,
    output logic [5:0]          w_idx,
    output logic                w_last
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;
    localparam logic [5:0] c_last    = 6'(ROUNDS - 1);

    logic [0:0] r_state;
    logic [5:0] r_cnt;
    word_t      r_win [16];
    word_t      w_new;
    logic       w_is_last;

    sha256_w_next u_w_next (
        .win0  (r_win[0]),
        .win1  (r_win[1]),
        .win9  (r_win[9]),
        .win14 (r_win[14]),
        .w_new (w_new)
    );

    assign w_is_last = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (blk_valid) begin
                        r_state <= c_st_run;
                        r_cnt   <= '0;
                        for (int i = 0; i < 16; i++) begin
                            r_win[i] <= blk_data[16*WORD_W-1-32*i -: 32];
                        end
                    end
                end
                c_st_run: begin
                    // Window slides only on a handshake so stalled outputs hold.
                    if (w_ready) begin
                        for (int i = 0; i < 15; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[15] <= w_new;
                        r_cnt     <= r_cnt + 6'd1;
                        if (w_is_last) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign blk_ready = (r_state == c_st_idle);
    assign w_valid   = (r_state == c_st_run);
    assign w_data    = r_win[0];
    assign w_idx     = r_cnt;
    assign w_last    = (r_state == c_st_run) && w_is_last;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_schedule
// Description : Directed self-checking bench for the SHA-256 message schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;
    import sha256_pkg::*;

    typedef word_t sched_t [64];
    typedef struct {
        int    idx;
        word_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       blk_valid;
    logic       blk_ready;
    block_t     blk_data;
    logic       w_valid;
    logic       w_ready;
    word_t      w_data;
    logic [5:0] w_idx;
    logic       w_last;

    int checks = 0;
    int errors = 0;

    sha256_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic word_t rotr(input word_t x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic void model(input block_t b, output sched_t w);
        for (int t = 0; t < 16; t++) begin
            w[t] = b[511-32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
    endfunction

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic send_block(input block_t b);
        int k;
        k = 0;
        blk_data  = b;
        blk_valid = 1'b1;
        while (!blk_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!blk_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got blk_ready=0 expected 1");
        end
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic collect(input int pct, input sched_t exp, input string tag, output sched_t got);
        int         beat;
        int         cyc;
        logic       stalled;
        word_t      pd;
        logic [5:0] pi;
        logic       pl;
        beat    = 0;
        cyc     = 0;
        stalled = 1'b0;
        pd      = '0;
        pi      = '0;
        pl      = 1'b0;
        for (int i = 0; i < 64; i++) got[i] = '0;
        while (beat < 64 && cyc < 3000) begin
            w_ready = ($urandom_range(99) < pct);
            check({tag, "_valid"}, 32'(w_valid), 32'd1);
            check({tag, "_busy"}, 32'(blk_ready), 32'd0);
            if (stalled) begin
                check({tag, "_stall_data"}, w_data, pd);
                check({tag, "_stall_idx"}, 32'(w_idx), 32'(pi));
                check({tag, "_stall_last"}, 32'(w_last), 32'(pl));
            end
            if (w_valid && w_ready) begin
                got[beat] = w_data;
                check({tag, "_data"}, w_data, exp[beat]);
                check({tag, "_idx"}, 32'(w_idx), 32'(beat));
                check({tag, "_last"}, 32'(w_last), 32'(beat == 63));
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = w_valid;
                pd = w_data;
                pi = w_idx;
                pl = w_last;
            end
            @(negedge clk);
            cyc++;
        end
        if (beat < 64) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats expected 64", tag, beat);
        end
        check({tag, "_end_ready"}, 32'(blk_ready), 32'd1);
        check({tag, "_end_valid"}, 32'(w_valid), 32'd0);
    endtask

    initial begin
        block_t blk_abc;
        block_t blk_b2;
        block_t blk_zero;
        sched_t exp_abc;
        sched_t exp_b2;
        sched_t exp_zero;
        sched_t got;
        vec_t   tbl [9];
        int     k;

        blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
        blk_zero = '0;
        for (int i = 0; i < 16; i++) begin
            blk_b2[511-32*i -: 32] = 32'h0123_4567 * (i + 1) ^ 32'hA5A5_0F0F;
        end
        model(blk_abc, exp_abc);
        model(blk_b2, exp_b2);
        model(blk_zero, exp_zero);

        tbl[0] = '{0,  32'h61626380};
        tbl[1] = '{1,  32'h00000000};
        tbl[2] = '{7,  32'h00000000};
        tbl[3] = '{14, 32'h00000000};
        tbl[4] = '{15, 32'h00000018};
        tbl[5] = '{16, 32'h61626380};
        tbl[6] = '{17, 32'h000F0000};
        tbl[7] = '{18, 32'h7DA86405};
        tbl[8] = '{63, 32'h12B1EDEB};

        rst       = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
        check("rst_w_valid",   32'(w_valid),   32'd0);
        check("rst_w_data",    w_data,         32'd0);
        check("rst_w_idx",     32'(w_idx),     32'd0);
        check("rst_w_last",    32'(w_last),    32'd0);

        // Full-rate "abc" block against the known schedule words.
        send_block(blk_abc);
        collect(100, exp_abc, "abc", got);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("abc_tbl_w%0d", tbl[i].idx), got[tbl[i].idx], tbl[i].exp);
        end

        // Same block under random backpressure.
        send_block(blk_abc);
        collect(30, exp_abc, "bp", got);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("bp_tbl_w%0d", tbl[i].idx), got[tbl[i].idx], tbl[i].exp);
        end

        // Second block waits with blk_valid high for the whole first block.
        send_block(blk_abc);
        blk_data  = blk_b2;
        blk_valid = 1'b1;
        collect(100, exp_abc, "b2b_first", got);
        @(negedge clk);
        blk_valid = 1'b0;
        collect(100, exp_b2, "b2b_second", got);

        // Reset held 2 cycles mid-block at idx 20.
        send_block(blk_b2);
        w_ready = 1'b1;
        k = 0;
        while (w_idx != 6'd20 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_idx", 32'(w_idx), 32'd20);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid_drop", 32'(w_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_blk_ready", 32'(blk_ready), 32'd1);
        check("abort_w_valid",   32'(w_valid),   32'd0);
        check("abort_w_idx",     32'(w_idx),     32'd0);
        check("abort_w_data",    w_data,         32'd0);
        repeat (2) @(negedge clk);
        check("abort_quiet", 32'(w_valid), 32'd0);
        send_block(blk_abc);
        collect(100, exp_abc, "restart", got);

        // All-zero block yields all-zero schedule.
        send_block(blk_zero);
        collect(60, exp_zero, "zero", got);
        for (int i = 0; i < 64; i += 21) begin
            check($sformatf("zero_w%0d", i), got[i], 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
